coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Front-end stage that feeds the newspaper vending controller's 2-bit coin input.
- Synchronises and debounces the raw 5-cent and 10-cent slot sensors.
- Turns each accepted insertion into one queued coin event.
- Issues queued events as single-cycle coin codes, paced by the controller's newspaper (dispense) output, so no coin is lost while a paper is being issued.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronised sensor level must differ from the debounced level before the debounced level flips (>=2).
PTR_W, 2, FIFO pointer width; FIFO depth = 2**PTR_W entries.

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clock
sense_5  input  1  raw asynchronous 5-cent slot sensor, high while a coin passes
sense_10  input  1  raw asynchronous 10-cent slot sensor, high while a coin passes
busy  input  1  tied to vending controller newspaper output; 1 = dispensing
coin  output  2  registered coin code to controller: 00 none, 01 five, 10 ten (11 never driven)
pending  output  PTR_W+1  number of queued, not yet issued coins
overflow  output  1  sticky; set when a coin event is dropped because the FIFO is full

Behaviour:
- Reset (reset==0 at a clock edge), including mid-operation:
  - coin=00, pending=0, overflow=0.
  - FIFO emptied; synchroniser flops, debounce counters and debounced levels cleared to 0.
  - Reset overrides all other activity in that cycle.
- Synchroniser: two flops per sensor line; only the second-stage value is used downstream.
- Debounce, per line, independent:
  - Counter increments while the synchronised level differs from the debounced level.
  - Counter clears to 0 on any cycle the levels match.
  - When the counter reaches DEB_CYCLES-1 with the levels still differing, the debounced level flips and the counter clears.
  - Pulses shorter than DEB_CYCLES cycles are ignored.
  - A sensor held high through reset release produces one event after DEB_CYCLES.
- Event: a rising edge of a debounced level is one coin event (01 for the 5-cent line, 10 for the 10-cent line). The falling edge produces nothing.
- Sensor-to-push latency: 2 sync + DEB_CYCLES cycles; the push is registered one cycle later.
- FIFO: up to two pushes and one pop per cycle.
  - Same-cycle events from both lines: the five (01) entry goes in first, then the ten (10).
  - Space check is free = depth - count + pop. The five is accepted first if space allows, then the ten. Each rejected event sets overflow; accepted ones are kept.
  - pending reflects the count after the edge.
- Issue rule: coin is a register.
  - At an edge, if busy==0, the FIFO is non-empty and the current coin==00: coin<=head and the entry is popped.
  - Otherwise coin<=00.
  - Result: coin is never non-zero in two consecutive cycles; every issued code lasts exactly one cycle.
  - The mandatory gap cycle lets the controller's state (and hence busy) settle before the next issue.
- busy rising while the FIFO is non-empty: issue stalls and entries are retained; issue resumes on the first edge with busy==0.
- Pointers wrap modulo 2**PTR_W. Full/empty are distinguished by count, never by pointer equality alone.
- overflow clears only on reset.

Test Plan:
- Single 5-cent coin: sense_5 high 10 cycles with 3 bounce toggles at the start, DEB_CYCLES=4 -> exactly one coin=01 for one cycle; no further event on release; pending returns to 0.
- Glitch rejection: sense_10 high for 3 cycles, then low -> coin stays 00, pending=0.
- Paced issue with real controller: two 10-cent coins queued back-to-back -> first 10 issued, next cycle 00, second 10 issued; controller reaches S15. Third queued 5 is held while newspaper=1 and issued on the first cycle newspaper=0.
- Simultaneous events: sense_5 and sense_10 debounced on the same cycle with an empty FIFO -> pending=2; issued order 01 then 10, separated by one 00 cycle.
- Overflow: busy held 1 and 5 coins inserted with depth 4 -> pending=4, overflow=1, coin stays 00. Release busy -> exactly 4 codes issued, in insertion order.
- Reset mid-operation: pending=3 and a debounce in progress, reset=0 for 1 cycle -> coin=00, pending=0, overflow=0 the next cycle. No event from the pre-reset debounce unless the sensor is still high for DEB_CYCLES after reset release.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Bundle between the slot sensors / vending controller and the coin acceptor.
// The master drives the sensors and busy; the slave (acceptor) returns coin status.
interface coin_acceptor_if #(
    parameter int PTR_W = 2
);
    logic             sense_5;
    logic             sense_10;
    logic             busy;
    logic [1:0]       coin;
    logic [PTR_W:0]   pending;
    logic             overflow;

    modport master (
        output sense_5, sense_10, busy,
        input  coin, pending, overflow
    );

    modport slave (
        input  sense_5, sense_10, busy,
        output coin, pending, overflow
    );
endinterface

// File: rtl/coin_acceptor.sv
// Synchronises and debounces the two coin slot sensors, queues coin events and
// issues them to the vending controller as one-cycle codes paced by busy.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int PTR_W      = 2
) (
    input  logic           clock,
    input  logic           reset,
    coin_acceptor_if.slave bus
);
    localparam int DEPTH = 2 ** PTR_W;
    localparam int CNT_W = $clog2(DEB_CYCLES);

    // Index 0 is the 5-cent line, index 1 the 10-cent line.
    logic [1:0]       sense;
    logic [1:0]       meta_q, sync_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, wr10;
    logic [PTR_W:0]   fill_q, fill_d;
    logic [1:0]       coin_q, coin_d;
    logic             ovf_q, ovf_d;
    logic             pop, acc5, acc10;
    logic [PTR_W+1:0] free;

    assign sense = {bus.sense_10, bus.sense_5};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            ev_d[i]  = 1'b0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync_q[i];
                    ev_d[i]  = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Space counts the slot freed by this cycle's pop; the five claims space before the ten.
    always_comb begin
        pop    = !bus.busy && (fill_q != '0) && (coin_q == 2'b00);
        free   = (PTR_W+2)'(DEPTH) - {1'b0, fill_q} + (PTR_W+2)'(pop);
        acc5   = ev_q[0] && (free != '0);
        acc10  = ev_q[1] && (free >= (acc5 ? (PTR_W+2)'(2) : (PTR_W+2)'(1)));
        wr10   = wr_q + PTR_W'(acc5);
        wr_d   = wr_q + PTR_W'(acc5) + PTR_W'(acc10);
        rd_d   = rd_q + PTR_W'(pop);
        fill_d = fill_q + (PTR_W+1)'(acc5) + (PTR_W+1)'(acc10) - (PTR_W+1)'(pop);
        coin_d = pop ? mem_q[rd_q] : 2'b00;
        ovf_d  = ovf_q | (ev_q[0] & ~acc5) | (ev_q[1] & ~acc10);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            deb_q    <= '0;
            ev_q     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
            coin_q   <= 2'b00;
            ovf_q    <= 1'b0;
        end else begin
            meta_q   <= sense;
            sync_q   <= meta_q;
            deb_q    <= deb_d;
            ev_q     <= ev_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            fill_q   <= fill_d;
            coin_q   <= coin_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by fill_q and the pointers.
    always_ff @(posedge clock) begin
        if (reset && acc5) begin
            mem_q[wr_q] <= 2'b01;
        end
        if (reset && acc10) begin
            mem_q[wr10] <= 2'b10;
        end
    end

    assign bus.coin     = coin_q;
    assign bus.pending  = fill_q;
    assign bus.overflow = ovf_q;
endmodule
